bcd_count_streamer: RTL and testbench
=====================================

Name: bcd_count_streamer

Overview:
Multi-digit synchronous BCD up/down counter with parallel load, plus a digit-serial output port. The port streams a snapshot of the count one 4-bit BCD digit at a time, most-significant digit first, under a valid/ready handshake. It sits directly upstream of the BCD-to-excess-3 converter: dig_data[3:0] drives the converter's a,b,c,d inputs (a = dig_data[3] MSB, d = dig_data[0] LSB). Counting continues undisturbed while a snapshot streams out.

Parameters:
DIGITS, 2, number of BCD digits in the counter (legal 1..8)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
en  input  1  count step enable, one step per cycle while high
up_dn  input  1  1 = count up, 0 = count down
load  input  1  parallel load strobe; has priority over en
load_val  input  4*DIGITS  load value; digit k in bits [4k+3:4k], digit 0 = LSD
snap  input  1  request to capture the count and stream it out
count  output  4*DIGITS  current count, same digit packing as load_val
tc  output  1  one-cycle pulse on wrap (up: all-9s to all-0s; down: all-0s to all-9s)
load_err  output  1  one-cycle pulse when a load contained a digit greater than 9
busy  output  1  high while a snapshot is being streamed
dig_valid  output  1  dig_data holds a valid digit
dig_ready  input  1  downstream accepts the digit this cycle
dig_data  output  4  BCD digit being offered, bit 3 = a (MSB) ... bit 0 = d (LSB)
dig_last  output  1  high with dig_valid on the LSD (final digit of a snapshot)

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. All state updates on the rising edge.
- Reset values: count = 0, tc = 0, load_err = 0, busy = 0, dig_valid = 0, dig_data = 0, dig_last = 0, FSM = IDLE.
- rst mid-stream: abandons the snapshot and clears every output on the same edge.
- Counter priority is rst > load > en.
- load: count <= load_val next edge. Any digit above 9 is loaded as 0, and load_err pulses for 1 cycle. tc = 0 on a load cycle.
- en with up_dn = 1: LSD increments.
  - A digit at 9 goes to 0 and carries into the next digit.
  - An all-9s count goes to all-0s, with tc = 1 for that one cycle (registered, aligned with the new count).
- en with up_dn = 0: LSD decrements.
  - A digit at 0 goes to 9 and borrows from the next digit.
  - An all-0s count goes to all-9s, with tc = 1.
- count never holds a digit above 9.
- en = 0 and load = 0: count holds.
- FSM state IDLE:
  - busy = 0, dig_valid = 0.
  - snap = 1 captures the count register value present before this edge's update into a shadow register, sets the digit index to DIGITS-1, and moves to SEND.
  - The snapshot therefore equals the value visible on count during the snap cycle.
- FSM state SEND:
  - busy = 1, dig_valid = 1, dig_data = shadow digit at the index, dig_last = (index == 0).
  - First digit valid 1 cycle after snap.
  - A transfer happens when dig_valid && dig_ready. On transfer with index > 0: index decrements.
  - With dig_ready = 0: dig_data and dig_last hold stable.
  - On transfer of the last digit: return to IDLE, so dig_valid and busy drop the next cycle.
  - snap is ignored while busy = 1, including on the cycle of the final transfer. No queuing.
- Throughput: with dig_ready held high, a snapshot streams in DIGITS cycles. The next snap is accepted at the earliest 1 cycle after busy falls.
- DIGITS = 1: dig_last = 1 on the only digit.
- Count path and stream path are independent. en/load during SEND change count but not the streamed shadow.

Test Plan:
1. DIGITS = 2. Reset, then en = 1, up_dn = 1 for 100 cycles -> count goes 00,01,...,99,00. tc = 1 exactly once, on the cycle count shows 00 after 99. count[7:4] steps 0→1 when the LSD wraps 9→0.
2. Load 8'h05 with up_dn = 0, en = 1 -> 04,03,02,01,00,99. tc pulses with 99. Then load 8'h3C -> count = 8'h30, load_err pulses 1 cycle. Load and en together -> the load wins.
3. count = 47, snap = 1, dig_ready = 1 -> next cycle dig_data = 4, dig_last = 0. Following cycle dig_data = 7, dig_last = 1. Then dig_valid = 0, busy = 0. The converter output is 0111 then 1010.
4. Backpressure: snap at 62 with dig_ready = 0 for 3 cycles -> dig_data stays 6, stable. Then ready -> 6 accepted, then 2. Meanwhile en increments count to 65 and the stream is unaffected.
5. snap asserted while busy and on the last-transfer cycle -> ignored, no second stream. snap 1 cycle after busy falls -> accepted.
6. rst asserted during SEND after the first digit -> next cycle all outputs 0, IDLE. A fresh snap afterwards streams 0,0.

Source files
------------

// File: rtl/bcd_count_streamer.sv
// bcd_count_streamer: multi-digit BCD up/down counter with parallel load and a
// digit-serial snapshot port that streams the count MSD first under valid/ready.
module bcd_count_streamer #(
    parameter int unsigned DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  snap,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  load_err,
    output logic                  busy,
    output logic                  dig_valid,
    input  logic                  dig_ready,
    output logic [3:0]            dig_data,
    output logic                  dig_last
);
    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    logic [W-1:0]  count_q, count_d;
    logic          tc_q, tc_d;
    logic          load_err_q, load_err_d;
    state_t        state_q, state_d;
    logic [W-1:0]  shadow_q, shadow_d;
    logic [IW-1:0] idx_q, idx_d;

    // Ripple carry/borrow through the digits; a carry out of the MSD is the wrap.
    always_comb begin : count_next
        logic       carry;
        logic [3:0] dig;
        count_d    = count_q;
        tc_d       = 1'b0;
        load_err_d = 1'b0;
        carry      = 1'b0;
        dig        = '0;
        if (load) begin
            for (int unsigned k = 0; k < DIGITS; k++) begin
                dig = load_val[4*k +: 4];
                if (dig > 4'd9) begin
                    count_d[4*k +: 4] = '0;
                    load_err_d        = 1'b1;
                end else begin
                    count_d[4*k +: 4] = dig;
                end
            end
        end else if (en) begin
            carry = 1'b1;
            for (int unsigned k = 0; k < DIGITS; k++) begin
                dig = count_q[4*k +: 4];
                if (carry) begin
                    if (up_dn) begin
                        if (dig == 4'd9) begin
                            dig = 4'd0;
                        end else begin
                            dig   = dig + 4'd1;
                            carry = 1'b0;
                        end
                    end else begin
                        if (dig == 4'd0) begin
                            dig = 4'd9;
                        end else begin
                            dig   = dig - 4'd1;
                            carry = 1'b0;
                        end
                    end
                end
                count_d[4*k +: 4] = dig;
            end
            tc_d = carry;
        end
    end

    // Snapshot takes the pre-update count so it matches what count shows this cycle.
    always_comb begin : stream_next
        state_d  = state_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        case (state_q)
            IDLE: begin
                if (snap) begin
                    state_d  = SEND;
                    shadow_d = count_q;
                    idx_d    = IW'(DIGITS - 1);
                end
            end
            SEND: begin
                if (dig_ready) begin
                    if (idx_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q - IW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            tc_q       <= 1'b0;
            load_err_q <= 1'b0;
            state_q    <= IDLE;
            shadow_q   <= '0;
            idx_q      <= '0;
        end else begin
            count_q    <= count_d;
            tc_q       <= tc_d;
            load_err_q <= load_err_d;
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            idx_q      <= idx_d;
        end
    end

    assign count     = count_q;
    assign tc        = tc_q;
    assign load_err  = load_err_q;
    assign busy      = (state_q == SEND);
    assign dig_valid = (state_q == SEND);
    assign dig_data  = (state_q == SEND) ? 4'(shadow_q >> {idx_q, 2'b00}) : '0;
    assign dig_last  = (state_q == SEND) && (idx_q == '0);

endmodule

// File: tb/tb_bcd_count_streamer.sv
// tb_bcd_count_streamer: vector table, directed stream sequences and random
// stimulus checked against an integer-valued reference model.
module tb_bcd_count_streamer;
    localparam int D   = 2;
    localparam int W   = 4 * D;
    localparam int MOD = 100;

    logic         clk = 1'b0;
    logic         rst, en, up_dn, load, snap, dig_ready;
    logic [W-1:0] load_val, count;
    logic         tc, load_err, busy, dig_valid, dig_last;
    logic [3:0]   dig_data;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: count as a plain integer, pending stream as a digit queue
    int m_val;
    bit m_tc, m_err, m_busy;
    int m_q[$];

    always #5 clk = ~clk;

    bcd_count_streamer #(.DIGITS(D)) dut (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .snap(snap), .count(count), .tc(tc),
        .load_err(load_err), .busy(busy), .dig_valid(dig_valid),
        .dig_ready(dig_ready), .dig_data(dig_data), .dig_last(dig_last)
    );

    function automatic int pow10(int k);
        int p = 1;
        for (int i = 0; i < k; i++) p *= 10;
        return p;
    endfunction

    function automatic logic [W-1:0] to_bcd(int v);
        logic [W-1:0] r = '0;
        for (int k = 0; k < D; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_val = 0; m_tc = 0; m_err = 0; m_busy = 0; m_q.delete();
            return;
        end
        if (m_busy) begin
            if (dig_ready) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_busy = 0;
            end
        end else if (snap) begin
            m_busy = 1;
            m_q.delete();
            for (int k = D - 1; k >= 0; k--) m_q.push_back((m_val / pow10(k)) % 10);
        end
        m_tc = 0; m_err = 0;
        if (load) begin
            int v = 0;
            for (int k = 0; k < D; k++) begin
                int nib = int'(load_val[4*k +: 4]);
                if (nib > 9) m_err = 1;
                else v += nib * pow10(k);
            end
            m_val = v;
        end else if (en) begin
            if (up_dn) begin
                m_tc  = (m_val == MOD - 1);
                m_val = (m_val + 1) % MOD;
            end else begin
                m_tc  = (m_val == 0);
                m_val = (m_val + MOD - 1) % MOD;
            end
        end
    endtask

    task automatic compare_all();
        chk("count", count, to_bcd(m_val));
        chk("tc", tc, m_tc);
        chk("load_err", load_err, m_err);
        chk("busy", busy, m_busy);
        chk("dig_valid", dig_valid, m_busy);
        chk("dig_data", dig_data, m_busy ? m_q[0] : 0);
        chk("dig_last", dig_last, m_busy && (m_q.size() == 1));
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    typedef struct {
        logic         ld;
        logic [W-1:0] lv;
        logic         e;
        logic         ud;
        logic [W-1:0] exp_count;
        logic         exp_tc;
        logic         exp_err;
    } vec_t;

    vec_t vecs[$];
    int   tc_seen;

    initial begin
        vecs.push_back('{1, 8'h05, 0, 0, 8'h05, 0, 0});
        vecs.push_back('{0, 8'h00, 1, 0, 8'h04, 0, 0});
        vecs.push_back('{0, 8'h00, 1, 0, 8'h03, 0, 0});
        vecs.push_back('{0, 8'h00, 1, 0, 8'h02, 0, 0});
        vecs.push_back('{0, 8'h00, 1, 0, 8'h01, 0, 0});
        vecs.push_back('{0, 8'h00, 1, 0, 8'h00, 0, 0});
        vecs.push_back('{0, 8'h00, 1, 0, 8'h99, 1, 0});
        vecs.push_back('{1, 8'h3C, 0, 0, 8'h30, 0, 1});
        vecs.push_back('{0, 8'h00, 1, 0, 8'h29, 0, 0});
        vecs.push_back('{1, 8'h12, 1, 1, 8'h12, 0, 0});
        vecs.push_back('{1, 8'h99, 1, 1, 8'h99, 0, 0});
        vecs.push_back('{0, 8'h00, 1, 1, 8'h00, 1, 0});
        vecs.push_back('{1, 8'hF9, 0, 1, 8'h09, 0, 1});
        vecs.push_back('{0, 8'h00, 0, 1, 8'h09, 0, 0});

        rst = 1; en = 0; up_dn = 1; load = 0; load_val = '0; snap = 0; dig_ready = 0;
        cycle();
        chk("reset_count", count, 0);
        chk("reset_busy", busy, 0);
        rst = 0;

        // full up-count lap
        en = 1; up_dn = 1; tc_seen = 0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (tc) tc_seen++;
            if (i == 9) chk("lap_carry", count, 8'h10);
        end
        chk("lap_tc_once", tc_seen, 1);
        chk("lap_end", count, 8'h00);
        en = 0;

        // load / down-count / bad-digit table
        foreach (vecs[i]) begin
            load = vecs[i].ld; load_val = vecs[i].lv; en = vecs[i].e; up_dn = vecs[i].ud;
            cycle();
            chk("vec_count", count, vecs[i].exp_count);
            chk("vec_tc", tc, vecs[i].exp_tc);
            chk("vec_err", load_err, vecs[i].exp_err);
        end
        load = 0; en = 0;

        // basic stream of 47
        load = 1; load_val = 8'h47; cycle(); load = 0;
        snap = 1; dig_ready = 1; cycle(); snap = 0;
        chk("s47_d0", dig_data, 4); chk("s47_l0", dig_last, 0); chk("s47_v0", dig_valid, 1);
        cycle();
        chk("s47_d1", dig_data, 7); chk("s47_l1", dig_last, 1);
        cycle();
        chk("s47_done_v", dig_valid, 0); chk("s47_done_b", busy, 0);

        // backpressure with counting underneath
        load = 1; load_val = 8'h62; cycle(); load = 0;
        snap = 1; dig_ready = 0; en = 1; up_dn = 1; cycle(); snap = 0;
        chk("bp_first", dig_data, 6);
        cycle(); chk("bp_hold1", dig_data, 6);
        cycle(); chk("bp_hold2", dig_data, 6); en = 0;
        cycle(); chk("bp_hold3", dig_data, 6); chk("bp_hold_last", dig_last, 0);
        dig_ready = 1; cycle();
        chk("bp_second", dig_data, 2); chk("bp_last", dig_last, 1);
        cycle();
        chk("bp_idle", busy, 0); chk("bp_count", count, 8'h65);

        // snap held through busy and final transfer is ignored; next cycle accepted
        snap = 1; cycle(); chk("sn_busy", busy, 1);
        cycle(); chk("sn_ignored_mid", dig_data, 5);
        cycle(); chk("sn_no_queue", busy, 0);
        cycle(); chk("sn_accept", busy, 1); chk("sn_accept_d", dig_data, 6);
        snap = 0; cycle(); cycle();
        chk("sn_drained", busy, 0);

        // reset mid-stream
        snap = 1; cycle(); snap = 0; cycle();
        chk("rs_second", dig_last, 1);
        rst = 1; cycle(); rst = 0;
        chk("rs_valid", dig_valid, 0); chk("rs_data", dig_data, 0); chk("rs_last", dig_last, 0);
        chk("rs_count", count, 0);
        snap = 1; cycle(); snap = 0;
        chk("rs_fresh0", dig_data, 0); chk("rs_fresh0_l", dig_last, 0);
        cycle(); chk("rs_fresh1", dig_data, 0); chk("rs_fresh1_l", dig_last, 1);
        cycle();

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            load      = ($urandom_range(0, 7) == 0);
            load_val  = W'($urandom);
            en        = $urandom_range(0, 1) == 1;
            up_dn     = $urandom_range(0, 1) == 1;
            snap      = ($urandom_range(0, 3) == 0);
            dig_ready = $urandom_range(0, 2) != 0;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
